// File: rtl/wwd_display_driver_pkg.sv
// Shared constants for the WWD display driver: digit count, segment bit order and hex glyphs.
// Segment vectors are {g,f,e,d,c,b,a}, active low.
package wwd_display_driver_pkg;

    localparam int unsigned DISP_DIGITS = 4;

    localparam int unsigned SEG_BIT_A = 0;
    localparam int unsigned SEG_BIT_B = 1;
    localparam int unsigned SEG_BIT_C = 2;
    localparam int unsigned SEG_BIT_D = 3;
    localparam int unsigned SEG_BIT_E = 4;
    localparam int unsigned SEG_BIT_F = 5;
    localparam int unsigned SEG_BIT_G = 6;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/wwd_display_driver_hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment glyph decoder.
module wwd_display_driver_hex_to_seg7
    import wwd_display_driver_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_0;
        case (nibble)
            4'h0: seg_n = SEG_0;
            4'h1: seg_n = SEG_1;
            4'h2: seg_n = SEG_2;
            4'h3: seg_n = SEG_3;
            4'h4: seg_n = SEG_4;
            4'h5: seg_n = SEG_5;
            4'h6: seg_n = SEG_6;
            4'h7: seg_n = SEG_7;
            4'h8: seg_n = SEG_8;
            4'h9: seg_n = SEG_9;
            4'hA: seg_n = SEG_A;
            4'hB: seg_n = SEG_B;
            4'hC: seg_n = SEG_C;
            4'hD: seg_n = SEG_D;
            4'hE: seg_n = SEG_E;
            4'hF: seg_n = SEG_F;
            default: seg_n = SEG_0;
        endcase
    end

endmodule

// File: rtl/wwd_display_driver.sv
// Captures the CPU's WWD output value and scans it as 4 hex digits on a multiplexed display;
// also mirrors the low PC byte onto LEDs and tracks capture statistics.
module wwd_display_driver
    import wwd_display_driver_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned NEW_HOLD = 25000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [15:0]            output_port,
    input  logic                   wwd_valid,
    input  logic [7:0]             PC_below8bit,
    input  logic                   freeze,
    output logic [6:0]             seg_n,
    output logic [DISP_DIGITS-1:0] an_n,
    output logic [7:0]             led,
    output logic                   new_flag,
    output logic                   missed,
    output logic [7:0]             wwd_count
);

    localparam logic [19:0] PRESC_LAST = 20'(SCAN_DIV - 1);
    localparam logic [31:0] HOLD_LAST  = 32'(NEW_HOLD - 1);

    logic [19:0]            presc_q;
    logic [1:0]             digit_q;
    logic [15:0]            disp_val_q;
    logic [31:0]            hold_q;
    logic                   new_flag_q;
    logic                   missed_q;
    logic [7:0]             count_q;
    logic [7:0]             led_q;
    logic [6:0]             seg_q;
    logic [DISP_DIGITS-1:0] an_q;

    logic                   capture;
    logic                   presc_wrap;
    logic [3:0]             nibble;
    logic [6:0]             seg_d;
    logic [DISP_DIGITS-1:0] an_d;

    always_comb begin
        capture    = wwd_valid & ~freeze;
        presc_wrap = (presc_q == PRESC_LAST);
        nibble     = disp_val_q[4*digit_q +: 4];
        an_d       = ~({{(DISP_DIGITS-1){1'b0}}, 1'b1} << digit_q);
    end

    wwd_display_driver_hex_to_seg7 u_hex_to_seg7 (
        .nibble (nibble),
        .seg_n  (seg_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q    <= '0;
            digit_q    <= '0;
            disp_val_q <= '0;
            hold_q     <= '0;
            new_flag_q <= 1'b0;
            missed_q   <= 1'b0;
            count_q    <= '0;
            led_q      <= '0;
            seg_q      <= SEG_0;
            an_q       <= 4'b1110;
        end else begin
            presc_q <= presc_wrap ? 20'd0 : presc_q + 20'd1;
            if (presc_wrap) begin
                digit_q <= digit_q + 2'd1;
            end
            seg_q <= seg_d;
            an_q  <= an_d;
            led_q <= PC_below8bit;

            if (capture) begin
                disp_val_q <= output_port;
                hold_q     <= HOLD_LAST;
                new_flag_q <= 1'b1;
                missed_q   <= 1'b0;
                if (count_q != 8'hFF) begin
                    count_q <= count_q + 8'd1;
                end
            end else begin
                if (wwd_valid) begin
                    missed_q <= 1'b1;
                end
                // The flag drops on the edge where the hold count has already reached zero.
                if (new_flag_q) begin
                    if (hold_q == 32'd0) begin
                        new_flag_q <= 1'b0;
                    end else begin
                        hold_q <= hold_q - 32'd1;
                    end
                end
            end
        end
    end

    assign seg_n     = seg_q;
    assign an_n      = an_q;
    assign led       = led_q;
    assign new_flag  = new_flag_q;
    assign missed    = missed_q;
    assign wwd_count = count_q;

endmodule

// File: tb/tb_wwd_display_driver.sv
// Self-checking bench: directed plus randomized steps compared against a cycle-count model.
module tb_wwd_display_driver;

    localparam int unsigned S = 4;
    localparam int unsigned H = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] data = '0;
    logic        valid = 1'b0;
    logic        freeze = 1'b0;
    logic [7:0]  pc = '0;

    logic [6:0] seg_n;
    logic [3:0] an_n;
    logic [7:0] led;
    logic       new_flag;
    logic       missed;
    logic [7:0] wwd_count;

    logic [6:0] f_seg_n;
    logic [3:0] f_an_n;
    logic [7:0] f_led;
    logic       f_new_flag;
    logic       f_missed;
    logic [7:0] f_wwd_count;

    wwd_display_driver #(.SCAN_DIV(S), .NEW_HOLD(H)) dut (
        .clk          (clk),
        .reset        (reset),
        .output_port  (data),
        .wwd_valid    (valid),
        .PC_below8bit (pc),
        .freeze       (freeze),
        .seg_n        (seg_n),
        .an_n         (an_n),
        .led          (led),
        .new_flag     (new_flag),
        .missed       (missed),
        .wwd_count    (wwd_count)
    );

    wwd_display_driver #(.SCAN_DIV(1), .NEW_HOLD(H)) dut_fast (
        .clk          (clk),
        .reset        (reset),
        .output_port  (data),
        .wwd_valid    (valid),
        .PC_below8bit (pc),
        .freeze       (freeze),
        .seg_n        (f_seg_n),
        .an_n         (f_an_n),
        .led          (f_led),
        .new_flag     (f_new_flag),
        .missed       (f_missed),
        .wwd_count    (f_wwd_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model state: edges since reset release, displayed value, capture bookkeeping.
    int          k;
    logic [15:0] m_disp;
    int          m_count;
    logic        m_missed;
    int          last_cap;
    bit          has_cap;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        k        = 0;
        m_disp   = '0;
        m_count  = 0;
        m_missed = 1'b0;
        last_cap = 0;
        has_cap  = 1'b0;
    endtask

    task automatic check_reset();
        check("rst_an_n", 16'(an_n), 16'h000E);
        check("rst_seg_n", 16'(seg_n), 16'h0040);
        check("rst_led", 16'(led), 16'h0000);
        check("rst_new_flag", 16'(new_flag), 16'h0000);
        check("rst_missed", 16'(missed), 16'h0000);
        check("rst_wwd_count", 16'(wwd_count), 16'h0000);
        check("rst_fast_an_n", 16'(f_an_n), 16'h000E);
        check("rst_fast_seg_n", 16'(f_seg_n), 16'h0040);
        check("rst_fast_count", 16'(f_wwd_count), 16'h0000);
    endtask

    task automatic tick(input logic v, input logic f, input logic [15:0] d);
        int         dig;
        logic [3:0] nib;
        logic [3:0] exp_an;
        logic [3:0] exp_fan;
        logic [6:0] exp_seg;
        logic [7:0] pc_now;
        valid  = v;
        freeze = f;
        data   = d;
        pc     = 8'($urandom);
        pc_now = pc;
        @(posedge clk);
        #1;
        k++;
        // Outputs after edge k reflect the digit selected before it.
        dig     = ((k - 1) / S) % 4;
        exp_an  = ~(4'b0001 << dig);
        exp_fan = ~(4'b0001 << ((k - 1) % 4));
        nib     = 4'(m_disp >> (4 * dig));
        exp_seg = hex_tab[nib];
        if (v && !f) begin
            m_disp   = d;
            m_count  = (m_count < 255) ? m_count + 1 : 255;
            m_missed = 1'b0;
            last_cap = k;
            has_cap  = 1'b1;
        end else if (v) begin
            m_missed = 1'b1;
        end
        check("an_n", 16'(an_n), 16'(exp_an));
        check("seg_n", 16'(seg_n), 16'(exp_seg));
        check("led", 16'(led), 16'(pc_now));
        check("new_flag", 16'(new_flag), 16'(has_cap && (k - last_cap) < int'(H)));
        check("missed", 16'(missed), 16'(m_missed));
        check("wwd_count", 16'(wwd_count), 16'(m_count));
        check("fast_an_n", 16'(f_an_n), 16'(exp_fan));
    endtask

    initial begin
        model_reset();
        #12;
        check_reset();
        @(negedge clk);
        reset = 1'b0;

        // Idle scan with random PC.
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 16'h0000);

        // Single capture, then watch the digits and the hold window.
        tick(1'b1, 1'b0, 16'hA5C3);
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 16'(i));

        // Strobe under freeze is dropped and flagged; next accepted strobe clears it.
        tick(1'b1, 1'b1, 16'h1234);
        for (int i = 0; i < 18; i++) tick(1'b0, 1'b0, 16'h0000);
        tick(1'b1, 1'b0, 16'h00FF);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 16'h0000);

        // Back-to-back strobes.
        tick(1'b1, 1'b0, 16'h1111);
        tick(1'b1, 1'b0, 16'h2222);
        tick(1'b1, 1'b0, 16'h3333);
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 16'h0000);

        // Drive the count to saturation.
        for (int i = 0; i < 300; i++) tick(1'b1, 1'b0, 16'($urandom));
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 16'h0000);

        // Random mix of strobes and freeze.
        for (int i = 0; i < 200; i++)
            tick(1'($urandom), ($urandom_range(3) == 0), 16'($urandom));

        // Position mid-slot of digit 2 with new_flag high, then reset asynchronously.
        for (int i = 0; i < 40 && !(((k / S) % 4) == 1 && (k % S) == 2); i++)
            tick(1'b0, 1'b0, 16'h0000);
        tick(1'b1, 1'b0, 16'hBEEF);
        for (int i = 0; i < 12 && !(((k / S) % 4) == 2 && (k % S) == 1); i++)
            tick(1'b0, 1'b0, 16'h0000);
        check("pre_rst_new_flag", 16'(new_flag), 16'h0001);
        #2;
        reset = 1'b1;
        #1;
        check_reset();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
